// File: rtl/reg_xfer_sequencer.sv
// Byte-serial transfers between the 8-bit CPU data bus and a bank of 16-bit byte-lane-writable registers.
// Optional build macro REG_XFER_ZEXT_EN: narrow loads with zext write 16'h00xx to both lanes.
module reg_xfer_sequencer #(
   parameter int NREG  = 8,
   parameter int SEL_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_en,
   input  logic                 start,
   input  logic                 dir,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 wide,
   input  logic                 hi_first,
   input  logic                 zext,
   input  logic [16*NREG-1:0]   reg_rdata,
   output logic [15:0]          reg_wdata,
   output logic [2*NREG-1:0]    reg_write,
   output logic                 bus_req,
   input  logic                 bus_ack,
   output logic                 bus_byte,
   input  logic [7:0]           bus_rdata,
   output logic [7:0]           bus_wdata,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, XFER0, XFER1, DONE} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] sel_q;
   logic             dir_q;
   logic             wide_q;
   logic             hi_first_q;   // already qualified by wide
   logic [15:0]      hold;
   logic [15:0]      snap;
   logic             lane;
   logic [1:0]       lanes;
   logic             in_xfer;

`ifdef REG_XFER_ZEXT_EN
   logic zext_q;

   always_ff @(posedge clk) begin
      if (reset)
         zext_q <= 1'b0;
      else if (cpu_en && state == IDLE && start)
         zext_q <= zext;
   end
`else
   logic unused_zext;
   assign unused_zext = zext;
`endif

   // Out-of-range selects snapshot zero, so stores of a missing register drive 0x00.
   always_comb begin
      snap = '0;
      for (int i = 0; i < NREG; i++)
         if (sel == SEL_W'(i)) snap = reg_rdata[16*i +: 16];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sel_q      <= '0;
         dir_q      <= 1'b0;
         wide_q     <= 1'b0;
         hi_first_q <= 1'b0;
         hold       <= '0;
      end else if (cpu_en) begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            sel_q      <= sel;
            dir_q      <= dir;
            wide_q     <= wide;
            hi_first_q <= hi_first & wide;
            hold       <= dir ? snap : 16'h0000;
         end
      end
   end

   // Only consulted when cpu_en is high, so bus_ack here is already qualified.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = XFER0;
         XFER0:   if (bus_ack) state_nxt = wide_q ? XFER1 : DONE;
         XFER1:   if (bus_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      reg_wdata = '0;
      reg_write = '0;
      bus_req   = 1'b0;
      bus_byte  = 1'b0;
      bus_wdata = '0;
      lanes     = 2'b00;
      in_xfer   = (state == XFER0) || (state == XFER1);
      lane      = (state == XFER1) ? ~hi_first_q : hi_first_q;
      // Outputs are forced quiet while reset is held so an aborted load never strobes.
      if (!reset && in_xfer) begin
         bus_req  = 1'b1;
         bus_byte = lane;
         if (dir_q) begin
            bus_wdata = lane ? hold[15:8] : hold[7:0];
         end else begin
            reg_wdata = {bus_rdata, bus_rdata};
            lanes     = lane ? 2'b10 : 2'b01;
`ifdef REG_XFER_ZEXT_EN
            if (!wide_q && zext_q) begin
               reg_wdata = {8'h00, bus_rdata};
               lanes     = 2'b11;
            end
`endif
            if (bus_ack && cpu_en)
               for (int i = 0; i < NREG; i++)
                  if (sel_q == SEL_W'(i)) reg_write[2*i +: 2] = lanes;
         end
      end
      busy = !reset && (state != IDLE);
      done = !reset && (state == DONE);
   end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed bench for reg_xfer_sequencer with a register-bank model and an expectation queue.
module tb_reg_xfer_sequencer;
   localparam int NREG  = 6;
   localparam int SEL_W = 3;

   logic                clk = 1'b0;
   logic                reset, cpu_en, start, dir, wide, hi_first, zext;
   logic [SEL_W-1:0]    sel;
   logic [16*NREG-1:0]  reg_rdata;
   logic [15:0]         reg_wdata;
   logic [2*NREG-1:0]   reg_write;
   logic                bus_req, bus_ack, bus_byte, busy, done;
   logic [7:0]          bus_rdata, bus_wdata;

   reg_xfer_sequencer #(.NREG(NREG), .SEL_W(SEL_W)) dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en), .start(start), .dir(dir), .sel(sel),
      .wide(wide), .hi_first(hi_first), .zext(zext), .reg_rdata(reg_rdata),
      .reg_wdata(reg_wdata), .reg_write(reg_write), .bus_req(bus_req), .bus_ack(bus_ack),
      .bus_byte(bus_byte), .bus_rdata(bus_rdata), .bus_wdata(bus_wdata), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Register bank model: captures DUT strobes, plus bench pokes for preload/overwrite.
   logic [15:0] regs [NREG];
   logic        poke;
   int          poke_idx;
   logic [15:0] poke_val;

   always @(posedge clk) begin
      if (poke) regs[poke_idx] <= poke_val;
      for (int i = 0; i < NREG; i++)
         for (int b = 0; b < 2; b++)
            if (reg_write[2*i+b]) regs[i][8*b +: 8] <= reg_wdata[8*b +: 8];
   end

   always_comb
      for (int i = 0; i < NREG; i++) reg_rdata[16*i +: 16] = regs[i];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit                is_done;
      logic              bbyte;
      bit                chk_wd;
      logic [7:0]        wd;
      logic [2*NREG-1:0] rw;
      bit                chk_rwd;
      logic [15:0]       rwd;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;

   task automatic push_beat(input logic bb, input bit cw, input logic [7:0] wd,
                            input logic [2*NREG-1:0] rw, input bit cr, input logic [15:0] rwd);
      exp_t e;
      e.is_done = 1'b0; e.bbyte = bb; e.chk_wd = cw; e.wd = wd;
      e.rw = rw; e.chk_rwd = cr; e.rwd = rwd;
      expq.push_back(e);
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1; e.bbyte = 1'b0; e.chk_wd = 1'b0; e.wd = '0;
      e.rw = '0; e.chk_rwd = 1'b0; e.rwd = '0;
      expq.push_back(e);
   endtask

   // Monitor: every completed byte and every done pulse must match the next expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus_req && bus_ack && cpu_en) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL beat_unexpected: got byte %0d with queue empty", bus_byte);
            end else begin
               mon_e = expq.pop_front();
               if (mon_e.is_done) begin
                  fails++;
                  $display("FAIL beat_order: got bus beat, expected done pulse");
               end else begin
                  check("bus_byte", 32'(bus_byte), 32'(mon_e.bbyte));
                  if (mon_e.chk_wd) check("bus_wdata", 32'(bus_wdata), 32'(mon_e.wd));
                  check("reg_write", 32'(reg_write), 32'(mon_e.rw));
                  if (mon_e.chk_rwd) check("reg_wdata", 32'(reg_wdata), 32'(mon_e.rwd));
               end
            end
         end else begin
            check("no_strobe", 32'(reg_write), 32'h0);
         end
         if (done && cpu_en) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL done_unexpected: got done with queue empty");
            end else begin
               mon_e = expq.pop_front();
               if (!mon_e.is_done) begin
                  fails++;
                  $display("FAIL done_order: got done, expected beat byte %0d", mon_e.bbyte);
               end
            end
         end
      end
   end

   task automatic cyc(input logic ack, input logic en, input logic [7:0] rd);
      bus_ack = ack; cpu_en = en; bus_rdata = rd;
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic d, input logic [SEL_W-1:0] s, input logic w,
                        input logic h, input logic z);
      dir = d; sel = s; wide = w; hi_first = h; zext = z;
      start = 1'b1; bus_ack = 1'b0; cpu_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic poke_reg(input int idx, input logic [15:0] val);
      poke = 1'b1; poke_idx = idx; poke_val = val;
      @(posedge clk); #1;
      poke = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cpu_en = 1'b1; start = 1'b0; dir = 1'b0; sel = '0; wide = 1'b0;
      hi_first = 1'b0; zext = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      poke = 1'b0; poke_idx = 0; poke_val = '0;
      @(posedge clk); #1;
      poke_reg(0, 16'hA5C3); poke_reg(1, 16'hBEEF); poke_reg(2, 16'hAAAA);
      poke_reg(3, 16'h3333); poke_reg(4, 16'h4444); poke_reg(5, 16'h5555);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_bus_req", 32'(bus_req), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_reg_write", 32'(reg_write), 32'h0);
      check("rst_outputs", {15'h0, bus_byte, bus_wdata, 8'h0}, 32'h0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
      reset = 1'b0;
      cyc(0, 1, 8'h00);

      // Wide load, low byte first, register 2
      issue(0, 3'd2, 1, 0, 0);
      push_beat(0, 0, 8'h00, 12'h010, 1, 16'h3434);
      push_beat(1, 0, 8'h00, 12'h020, 1, 16'h1212);
      push_done();
      cyc(1, 1, 8'h34); cyc(1, 1, 8'h12); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
      check("wide_load_r2", 32'(regs[2]), 32'h1234);

      // Wide store, high byte first; register overwritten after the snapshot
      issue(1, 3'd1, 1, 1, 0);
      poke_reg(1, 16'h0000);
      push_beat(1, 1, 8'hBE, 12'h000, 0, 16'h0);
      push_beat(0, 1, 8'hEF, 12'h000, 0, 16'h0);
      push_done();
      cyc(1, 1, 8'h00); cyc(1, 1, 8'h00); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
      check("store_no_write_r1", 32'(regs[1]), 32'h0000);

      // Narrow load; hi_first must be ignored
      issue(0, 3'd0, 0, 1, 1);
`ifdef REG_XFER_ZEXT_EN
      push_beat(0, 0, 8'h00, 12'h003, 1, 16'h007F);
`else
      push_beat(0, 0, 8'h00, 12'h001, 1, 16'h7F7F);
`endif
      push_done();
      cyc(1, 1, 8'h7F); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
`ifdef REG_XFER_ZEXT_EN
      check("narrow_load_r0", 32'(regs[0]), 32'h007F);
`else
      check("narrow_load_r0", 32'(regs[0]), 32'hA57F);
`endif

      // Stalled bus with cpu_en toggling and stray start pulses
      issue(0, 3'd3, 1, 0, 0);
      push_beat(0, 0, 8'h00, 12'h040, 1, 16'h5656);
      push_beat(1, 0, 8'h00, 12'h080, 1, 16'h7878);
      push_done();
      sel = 3'd4;
      for (int k = 0; k < 5; k++) begin
         start = k[0];
         cyc(0, (k % 2) == 0, 8'hEE);
         check("stall_bus_req", 32'(bus_req), 32'h1);
         check("stall_bus_byte", 32'(bus_byte), 32'h0);
      end
      start = 1'b0;
      cyc(1, 0, 8'hAB);
      check("ack_no_en_hold", 32'(bus_byte), 32'h0);
      cyc(1, 1, 8'h56);
      cyc(1, 0, 8'hCD);
      cyc(1, 1, 8'h78);
      cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
      check("stall_load_r3", 32'(regs[3]), 32'h7856);

      // Reset after the first byte of a wide load
      issue(0, 3'd4, 1, 0, 0);
      push_beat(0, 0, 8'h00, 12'h100, 1, 16'h9999);
      cyc(1, 1, 8'h99);
      reset = 1'b1; bus_ack = 1'b1; bus_rdata = 8'h66; cpu_en = 1'b1;
      #1;
      check("rst_mid_strobe", 32'(reg_write), 32'h0);
      check("rst_mid_bus_req", 32'(bus_req), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0; bus_ack = 1'b0;
      #1;
      check("after_rst_busy", 32'(busy), 32'h0);
      check("after_rst_bus_req", 32'(bus_req), 32'h0);
      cyc(0, 1, 8'h00);
      check("rst_partial_r4", 32'(regs[4]), 32'h4499);

      // Out-of-range select: full sequence, no strobes
      issue(0, 3'd7, 1, 0, 0);
      push_beat(0, 0, 8'h00, 12'h000, 1, 16'h1111);
      push_beat(1, 0, 8'h00, 12'h000, 1, 16'h2222);
      push_done();
      cyc(1, 1, 8'h11); cyc(1, 1, 8'h22); cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
      check("oob_r5_untouched", 32'(regs[5]), 32'h5555);
      check("oob_r2_untouched", 32'(regs[2]), 32'h1234);

      cyc(0, 1, 8'h00); cyc(0, 1, 8'h00);
      check("queue_empty", 32'(expq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
